prog_mem_loader: RTL and testbench

//  Writer side of the CPU program memory: a loadable 256 x 35-bit program RAM with a CPU read port

---
 rtl/prog_mem_loader.sv | 184 ++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Loadable 256 x 35-bit CPU program RAM fed by a byte stream; holds the CPU while loading.
// Optional macro CHECKSUM_EN adds an XOR trailer byte check after the data words.
module prog_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 35,
  parameter int NBYTES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   wr_count
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int SHW   = 8*(NBYTES-1);
  localparam int BCW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [ADDR_W:0] FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NBYTES-1);
  localparam logic [BCW-1:0]  BC_ONE    = BCW'(1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
`ifdef CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   target;
  logic [ADDR_W:0]   wr_inc;
  logic [BCW-1:0]    byte_cnt;
  logic [SHW-1:0]    shift;
  logic [DATA_W-1:0] word;
  logic              busy;
  logic              accept;
  logic              word_end;
  logic              last_word;

`ifdef CHECKSUM_EN
  logic [7:0] chk;
  logic       err_q;
  logic       chk_ok;

  assign chk_ok   = (rx_data == chk);
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  always_comb begin
    busy = 1'b0;
    case (state)
      HDR, DATA: busy = 1'b1;
`ifdef CHECKSUM_EN
      CHK:       busy = 1'b1;
`endif
      default:   busy = 1'b0;
    endcase
  end

  // A restart pulse takes priority, so a byte offered on the same edge is never consumed.
  assign accept    = rx_valid & busy & ~load_start;
  assign rx_ready  = busy;
  assign cpu_hold  = busy;
  assign load_done = (state == DONE);
  assign wr_count  = wr_cnt;

  // The current byte completes the word together with the bytes already shifted in.
  assign word      = DATA_W'({shift, rx_data});
  assign word_end  = accept && (state == DATA) && (byte_cnt == LAST_BYTE);
  assign last_word = ((wr_cnt + ONE) == target);
  assign wr_inc    = (wr_cnt == FULL) ? wr_cnt : (wr_cnt + ONE);

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = HDR;
    end else begin
      case (state)
        IDLE, DONE: state_nxt = state;
        HDR:        if (accept) state_nxt = DATA;
        DATA: begin
          if (word_end && last_word) begin
`ifdef CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = DONE;
`endif
          end
        end
`ifdef CHECKSUM_EN
        CHK:        if (accept) state_nxt = chk_ok ? DONE : IDLE;
`endif
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load bookkeeping: valid bits, word counter, header length and byte assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= '0;
      wr_cnt   <= '0;
      target   <= '0;
      byte_cnt <= '0;
      shift    <= '0;
`ifdef CHECKSUM_EN
      chk      <= '0;
      err_q    <= 1'b0;
`endif
    end else if (load_start) begin
      valid    <= '0;
      wr_cnt   <= '0;
      byte_cnt <= '0;
`ifdef CHECKSUM_EN
      chk      <= '0;
      err_q    <= 1'b0;
`endif
    end else if (accept) begin
      case (state)
        HDR: begin
          target <= (rx_data == 8'd0) ? FULL : (ADDR_W+1)'(rx_data);
        end
        DATA: begin
          shift <= SHW'({shift, rx_data});
`ifdef CHECKSUM_EN
          chk   <= chk ^ rx_data;
`endif
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt                   <= '0;
            valid[wr_cnt[ADDR_W-1:0]]  <= 1'b1;
            wr_cnt                     <= wr_inc;
          end else begin
            byte_cnt <= byte_cnt + BC_ONE;
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (!chk_ok) begin
            valid <= '0;
            err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // RAM array itself is deliberately unreset; the valid bits decide what the CPU sees.
  always_ff @(posedge clk) begin
    if (word_end) begin
      mem[wr_cnt[ADDR_W-1:0]] <= word;
    end
  end

  assign rd_data = (valid[rd_addr] && !busy) ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized self-checking bench for prog_mem_loader against a word-level memory model.
// Build with or without CHECKSUM_EN defined; the checksum scenario follows the macro.
module tb_prog_mem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rd_addr;
  logic [34:0] rd_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [8:0]  wr_count;

  int checks = 0;
  int errors = 0;

  logic [34:0] m_mem   [DEPTH];
  bit          m_valid [DEPTH];
  bit          m_hold, m_done, m_err;
  int          m_count;
  logic [34:0] words   [DEPTH];

  prog_mem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_valid();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    rx_valid   = 1'b0;
    load_start = 1'b0;
    #1;
    checkOutput({tag, "_cpu_hold"},  64'(cpu_hold),  64'(m_hold));
    checkOutput({tag, "_rx_ready"},  64'(rx_ready),  64'(m_hold));
    checkOutput({tag, "_load_done"}, 64'(load_done), 64'(m_done));
    checkOutput({tag, "_load_err"},  64'(load_err),  64'(m_err));
    checkOutput({tag, "_wr_count"},  64'(wr_count),  64'(m_count));
  endtask

  task automatic read_all(input string tag);
    logic [34:0] exp;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rd_addr  = 8'(a);
      #1;
      exp = (m_valid[a] && !m_hold) ? m_mem[a] : 35'd0;
      checkOutput($sformatf("%s_rd[%0d]", tag, a), 64'(rd_data), 64'(exp));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid   = 1'b0;
    load_start = 1'b1;
    model_clear_valid();
    m_hold  = 1'b1;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_count = 0;
  endtask

  // Offers one byte, with random idle gaps first, and returns once it will be taken on the next edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap_pct);
    int w;
    @(negedge clk);
    while (int'($urandom_range(99)) < gap_pct) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    w = 0;
    while (!rx_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    checkOutput("byte_rx_ready", 64'(rx_ready), 64'd1);
    checkOutput("byte_cpu_hold", 64'(cpu_hold), 64'd1);
  endtask

  task automatic run_load(input string tag, input int n, input int gap_pct,
                          input bit junk_en, input bit bad_chk);
    logic [39:0] full;
    logic [7:0]  x;
    logic [7:0]  b;
    logic [4:0]  jk;
    x = 8'h00;
    applyStimulus(8'(n), gap_pct);
    for (int i = 0; i < n; i++) begin
      jk   = junk_en ? 5'($urandom) : 5'd0;
      full = {jk, words[i]};
      for (int k = 4; k >= 0; k--) begin
        b = full[8*k +: 8];
        x = x ^ b;
        applyStimulus(b, gap_pct);
      end
    end
`ifdef CHECKSUM_EN
    if (bad_chk) applyStimulus((x != 8'h00) ? 8'h00 : 8'hFF, gap_pct);
    else         applyStimulus(x, gap_pct);
`endif
    for (int i = 0; i < n; i++) begin
      m_mem[i]   = words[i];
      m_valid[i] = 1'b1;
    end
    m_count = n;
    m_hold  = 1'b0;
    m_done  = 1'b1;
`ifdef CHECKSUM_EN
    if (bad_chk) begin
      model_clear_valid();
      m_done = 1'b0;
      m_err  = 1'b1;
    end
`endif
    check_status(tag);
  endtask

  task automatic random_words(input int n);
    for (int i = 0; i < n; i++) words[i] = 35'({$urandom, $urandom});
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    rd_addr    = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 35'd0;
      words[i] = 35'd0;
    end
    model_clear_valid();
    m_hold = 0; m_done = 0; m_err = 0; m_count = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    check_status("reset");
    read_all("reset");

    $display("[TB] basic two-word load");
    words[0] = 35'h5;
    words[1] = 35'h7FFFFFFFF;
    pulse_start();
    check_status("basic_start");
    run_load("basic", 2, 0, 1'b0, 1'b0);
    read_all("basic");

    $display("[TB] stray bytes while not ready, then back-pressured load");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      #1;
      checkOutput("idle_rx_ready", 64'(rx_ready), 64'd0);
    end
    pulse_start();
    check_status("gap_start");
    run_load("gap", 2, 50, 1'b0, 1'b0);
    read_all("gap");

    n = int'($urandom_range(3, 40));
    random_words(n);
    pulse_start();
    check_status("rand_start");
    run_load("rand", n, 40, 1'b1, 1'b0);
    read_all("rand");

    $display("[TB] restart mid-DATA with a colliding byte");
    random_words(2);
    pulse_start();
    check_status("restart_start");
    applyStimulus(8'd2, 0);
    for (int k = 0; k < 3; k++) applyStimulus(8'($urandom), 0);
    @(negedge clk);
    rx_valid   = 1'b1;
    rx_data    = 8'($urandom);
    load_start = 1'b1;
    model_clear_valid();
    m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0; m_count = 0;
    check_status("restart");
    read_all("restart_hold");
    random_words(1);
    run_load("restart_reload", 1, 20, 1'b1, 1'b0);
    read_all("restart_reload");

    $display("[TB] full 256-word load");
    for (int i = 0; i < DEPTH; i++) words[i] = 35'(i);
    pulse_start();
    check_status("full_start");
    run_load("full", 256, 10, 1'b1, 1'b0);
    @(negedge clk);
    rd_addr = 8'd255;
    #1;
    checkOutput("full_rd255", 64'(rd_data), 64'h0FF);
    read_all("full");

`ifdef CHECKSUM_EN
    $display("[TB] checksum mismatch");
    words[0] = 35'h5;
    words[1] = 35'h7FFFFFFFF;
    pulse_start();
    check_status("chk_start");
    run_load("chk_bad", 2, 0, 1'b0, 1'b1);
    read_all("chk_bad");
    pulse_start();
    check_status("chk_restart");
    run_load("chk_good", 2, 30, 1'b1, 1'b0);
    read_all("chk_good");
`endif

    $display("[TB] reset mid-DATA");
    random_words(3);
    pulse_start();
    check_status("midrst_start");
    applyStimulus(8'd3, 0);
    for (int k = 0; k < 7; k++) applyStimulus(8'($urandom), 0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    model_clear_valid();
    m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0; m_count = 0;
    check_status("midrst");
    read_all("midrst");
    @(negedge clk);
    reset = 1'b0;
    n = int'($urandom_range(1, 20));
    random_words(n);
    pulse_start();
    check_status("recover_start");
    run_load("recover", n, 30, 1'b1, 1'b0);
    read_all("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
